// File: rtl/memory_rom_arbiter_pkg.sv
// Shared constants and types for the two-port memory_rom read arbiter.
package memory_rom_arbiter_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic winner;
  } rr_pick_t;

endpackage

// File: rtl/memory_rom_arbiter_rr_select2.sv
// Combinational two-way round-robin pick: the requester that did not win last is preferred.
module rr_select2
  import memory_rom_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_last_i,
  output logic valid_o,
  output logic winner_o
);

  rr_pick_t pick;

  always_comb begin
    pick.valid  = req0_i | req1_i;
    pick.winner = REQ0;
    if (rr_last_i == REQ1) begin
      pick.winner = req0_i ? REQ0 : REQ1;
    end else begin
      pick.winner = req1_i ? REQ1 : REQ0;
    end
  end

  assign valid_o  = pick.valid;
  assign winner_o = pick.winner;

endmodule

// File: rtl/memory_rom_arbiter.sv
// Shares one 1-cycle-latency memory_rom between two requesters; round-robin with a
// bounded lock for bursts, data returned with a registered valid to the grant owner.
module memory_rom_arbiter
  import memory_rom_arbiter_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 4,
  parameter int unsigned D_WIDTH   = 48,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic               lock0,
  output logic               gnt0,
  output logic               rvalid0,
  output logic [D_WIDTH-1:0] rdata0,
  input  logic               req1,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic               lock1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata1,
  output logic [A_WIDTH-1:0] rom_adress,
  output logic               rom_re,
  input  logic [D_WIDTH-1:0] rom_data
);

  localparam int unsigned        CNT_W        = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]   CNT_LOCK_MAX = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = CNT_W'(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_valid_q, rd_owner_q;

  logic rr_valid, rr_winner;
  logic lock_win, grant_v, winner, lock_w;

  rr_select2 u_rr_select2 (
    .req0_i   (req0),
    .req1_i   (req1),
    .rr_last_i(rr_last_q),
    .valid_o  (rr_valid),
    .winner_o (rr_winner)
  );

  // Winner selection: a live lock with burst budget left beats round-robin.
  always_comb begin
    lock_win = 1'b0;
    winner   = rr_winner;
    grant_v  = 1'b0;
    if (!rst) begin
      if ((state_q == S_OWN0) && req0 && (burst_cnt_q < CNT_LOCK_MAX)) begin
        lock_win = 1'b1;
        winner   = REQ0;
      end else if ((state_q == S_OWN1) && req1 && (burst_cnt_q < CNT_LOCK_MAX)) begin
        lock_win = 1'b1;
        winner   = REQ1;
      end
      grant_v = lock_win | rr_valid;
    end
  end

  assign gnt0       = grant_v & (winner == REQ0);
  assign gnt1       = grant_v & (winner == REQ1);
  assign rom_re     = grant_v;
  assign rom_adress = grant_v ? ((winner == REQ1) ? addr1 : addr0) : '0;

  // Next-state: lock requests ownership, burst counter only advances on lock wins.
  always_comb begin
    state_d     = S_IDLE;
    burst_cnt_d = '0;
    rr_last_d   = rr_last_q;
    lock_w      = (winner == REQ1) ? lock1 : lock0;
    if (grant_v) begin
      rr_last_d = winner;
      if (lock_w) begin
        state_d = (winner == REQ1) ? S_OWN1 : S_OWN0;
      end
      if (lock_win) begin
        burst_cnt_d = (burst_cnt_q == CNT_SAT) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_last_q   <= REQ1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Owner id follows the ROM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= REQ0;
    end else begin
      rd_valid_q <= grant_v;
      rd_owner_q <= winner;
    end
  end

  assign rvalid0 = rd_valid_q & (rd_owner_q == REQ0);
  assign rvalid1 = rd_valid_q & (rd_owner_q == REQ1);
  assign rdata0  = rom_data;
  assign rdata1  = rom_data;

endmodule

// File: tb/tb_memory_rom_arbiter.sv
// Self-checking bench for memory_rom_arbiter with a behavioural ROM (mem[i] = A5A5_0000_000i).
module tb_memory_rom_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 48;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, rom_re;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_adress;
  logic [DW-1:0] rom_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  memory_rom_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_adress(rom_adress), .rom_re(rom_re), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 48'hA5A5_0000_0000 | DW'(a);
  endfunction

  always @(posedge clk) if (rom_re) rom_data <= rom_word(rom_adress);

  task automatic apply_reset();
    rst = 1'b1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; addr0 = '0; addr1 = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; addr0 = 4'd7;
    @(negedge clk); #1;
    n_checks++;
    if ({gnt0, gnt1, rom_re, rvalid0, rvalid1} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000", {gnt0, gnt1, rom_re, rvalid0, rvalid1});
    else n_pass++;
  endtask

  task automatic test_single_read();
    apply_reset();
    req0 = 1'b1; addr0 = 4'd3; #1;
    n_checks++;
    if ({gnt0, gnt1, rom_re} !== 3'b101 || rom_adress !== 4'd3)
      $display("FAIL single_grant: got g/re=%b adr=%0d expected 101 adr=3", {gnt0, gnt1, rom_re}, rom_adress);
    else n_pass++;
    @(negedge clk); req0 = 1'b0; #1;
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== rom_word(4'd3))
      $display("FAIL single_resp: got v=%b d=%h expected v=10 d=%h", {rvalid0, rvalid1}, rdata0, rom_word(4'd3));
    else n_pass++;
    n_checks++;
    if ({gnt0, gnt1, rom_re} !== 3'b000 || rom_adress !== 4'd0)
      $display("FAIL single_idle: got g/re=%b adr=%0d expected 000 adr=0", {gnt0, gnt1, rom_re}, rom_adress);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [1:0]    exp_g, exp_v;
    logic [DW-1:0] got_d, exp_d;
    apply_reset();
    addr0 = 4'd1; addr1 = 4'd2;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      req0 = (i < 6); req1 = (i < 6); #1;
      exp_g = (i < 6) ? (((i % 2) == 0) ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if ({gnt0, gnt1} !== exp_g)
        $display("FAIL alt_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, exp_g);
      else n_pass++;
      if (i > 0) begin
        exp_v = (((i - 1) % 2) == 0) ? 2'b10 : 2'b01;
        got_d = exp_v[1] ? rdata0 : rdata1;
        exp_d = exp_v[1] ? rom_word(4'd1) : rom_word(4'd2);
        n_checks++;
        if ({rvalid0, rvalid1} !== exp_v || got_d !== exp_d)
          $display("FAIL alt_resp[%0d]: got v=%b d=%h expected v=%b d=%h", i, {rvalid0, rvalid1}, got_d, exp_v, exp_d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_burst();
    int exp_w[6] = '{0, 0, 0, 0, 1, 0};
    int wait1 = 0;
    logic seen1 = 1'b0;
    apply_reset();
    lock0 = 1'b1; addr0 = 4'd4; addr1 = 4'd8;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; #1;
      n_checks++;
      if ({gnt0, gnt1} !== ((exp_w[i] == 0) ? 2'b10 : 2'b01))
        $display("FAIL burst_gnt[%0d]: got %b expected winner %0d", i, {gnt0, gnt1}, exp_w[i]);
      else n_pass++;
      if (gnt1) seen1 = 1'b1;
      if (!seen1 && !gnt1) wait1++;
    end
    n_checks++;
    if (!seen1 || wait1 > int'(MB))
      $display("FAIL burst_wait1: got wait=%0d granted=%b expected wait<=%0d granted=1", wait1, seen1, MB);
    else n_pass++;
    @(negedge clk); req0 = 0; req1 = 0; lock0 = 0;
  endtask

  task automatic test_solo_burst();
    apply_reset();
    lock1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      req1 = (i < 10); addr1 = AW'(i % 16); #1;
      n_checks++;
      if ({gnt0, gnt1} !== ((i < 10) ? 2'b01 : 2'b00))
        $display("FAIL solo_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, (i < 10) ? 2'b01 : 2'b00);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== rom_word(AW'(i - 1)))
          $display("FAIL solo_resp[%0d]: got v=%b d=%h expected v=01 d=%h", i, {rvalid0, rvalid1}, rdata1, rom_word(AW'(i - 1)));
        else n_pass++;
      end
    end
    lock1 = 1'b0;
  endtask

  task automatic test_reset_midread();
    apply_reset();
    req1 = 1'b1; addr1 = 4'd5; #1;
    n_checks++;
    if (gnt1 !== 1'b1) $display("FAIL midrst_gnt1: got %b expected 1", gnt1);
    else n_pass++;
    @(posedge clk); #1;
    req1 = 1'b0;
    n_checks++;
    if (rvalid1 !== 1'b1) $display("FAIL midrst_pre: got rvalid1=%b expected 1", rvalid1);
    else n_pass++;
    rst = 1'b1; #1;
    n_checks++;
    if ({rvalid0, rvalid1, gnt0, gnt1, rom_re} !== 5'b0)
      $display("FAIL midrst_drop: got %b expected 00000", {rvalid0, rvalid1, gnt0, gnt1, rom_re});
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({rvalid0, rvalid1} !== 2'b00)
        $display("FAIL midrst_post[%0d]: got %b expected 00", i, {rvalid0, rvalid1});
      else n_pass++;
    end
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'd9; #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL midrst_first: got %b expected 10", {gnt0, gnt1});
    else n_pass++;
    @(negedge clk); req0 = 1'b0; req1 = 1'b0; #1;
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata0 !== rom_word(4'd9))
      $display("FAIL midrst_resp: got v=%b d=%h expected v=10 d=%h", {rvalid0, rvalid1}, rdata0, rom_word(4'd9));
    else n_pass++;
  endtask

  task automatic test_idle();
    apply_reset();
    req0 = 1'b1; addr0 = 4'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); req0 = 1'b0; #1;
      n_checks++;
      if ({gnt0, gnt1, rom_re} !== 3'b000 || {rvalid0, rvalid1} !== ((i == 0) ? 2'b10 : 2'b00))
        $display("FAIL idle[%0d]: got g/re=%b v=%b expected 000 v=%b", i, {gnt0, gnt1, rom_re},
                 {rvalid0, rvalid1}, (i == 0) ? 2'b10 : 2'b00);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic          rq[2], rl[2], granted[2];
    logic [AW-1:0] ra[2];
    int            owner, run, last, w;
    logic          lockwin, pv;
    int            pw;
    logic [AW-1:0] pa, exp_adr;
    logic [DW-1:0] got_d;
    apply_reset();
    owner = -1; run = 0; last = 1; pv = 1'b0; pw = 0; pa = '0;
    for (int r = 0; r < 2; r++) begin rq[r] = 0; rl[r] = 0; ra[r] = '0; granted[r] = 0; end
    for (int step = 0; step < 400; step++) begin
      if (step > 0) @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!rq[r] || granted[r]) begin
          rq[r] = ($urandom_range(0, 2) != 0);
          ra[r] = AW'($urandom);
        end
        rl[r] = ($urandom_range(0, 3) != 0);
      end
      req0 = rq[0]; addr0 = ra[0]; lock0 = rl[0];
      req1 = rq[1]; addr1 = ra[1]; lock1 = rl[1];
      w = -1; lockwin = 1'b0;
      if (owner >= 0 && rq[owner] && run < int'(MB) - 1) begin
        w = owner; lockwin = 1'b1;
      end else if (rq[1 - last]) w = 1 - last;
      else if (rq[last]) w = last;
      exp_adr = (w >= 0) ? ((w == 1) ? ra[1] : ra[0]) : '0;
      #1;
      n_checks++;
      if ({gnt0, gnt1, rom_re} !== {w == 0, w == 1, w >= 0} || rom_adress !== exp_adr)
        $display("FAIL rand_gnt[%0d]: got g/re=%b adr=%0d expected winner %0d adr=%0d",
                 step, {gnt0, gnt1, rom_re}, rom_adress, w, exp_adr);
      else n_pass++;
      got_d = (pw == 1) ? rdata1 : rdata0;
      n_checks++;
      if ({rvalid0, rvalid1} !== {pv && pw == 0, pv && pw == 1} || (pv && got_d !== rom_word(pa)))
        $display("FAIL rand_resp[%0d]: got v=%b d=%h expected owner %0d valid %b d=%h",
                 step, {rvalid0, rvalid1}, got_d, pw, pv, rom_word(pa));
      else n_pass++;
      granted[0] = (w == 0); granted[1] = (w == 1);
      pv = (w >= 0); pw = (w >= 0) ? w : 0; pa = exp_adr;
      if (w >= 0) begin
        last  = w;
        run   = lockwin ? run + 1 : 0;
        owner = rl[w] ? w : -1;
      end else begin
        owner = -1; run = 0;
      end
    end
    @(negedge clk);
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_solo_burst();
    test_reset_midread();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
